bzled_seq_ctrl: RTL and testbench

Sequencer between the FlexBus register file and the buzzer/RGB PWM peripheral. In pass-through mode it forwards the host-written LED frequency, buzzer frequency and duty values unchanged. In breathe and colour-cycle modes it generates the RGB duty values autonomously: a saturating ramp up, hold, ramp down, hold. It also gates the buzzer frequency with a host-triggered timed beep.

---
 rtl/bzled_seq_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_bzled_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bzled_seq_ctrl.sv
// Duty/frequency sequencer between the FlexBus register file and the buzzer/RGB PWM block.
// Pass-through of host values, or autonomous breathe / colour-cycle ramps plus a timed beep gate.
module bzled_seq_ctrl #(
    parameter logic [31:0] PUTY_STEP  = 32'd100,
    parameter int unsigned HOLD_TICKS = 8,
    parameter int unsigned BEEP_TICKS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [1:0]  MODE,
    input  logic [31:0] STEP_DIV,
    input  logic [31:0] PUTY_MAX,
    input  logic [31:0] HOST_LED_FREQ,
    input  logic [31:0] HOST_BZ_FREQ,
    input  logic [31:0] HOST_LEDR_Puty,
    input  logic [31:0] HOST_LEDG_Puty,
    input  logic [31:0] HOST_LEDB_Puty,
    input  logic        BEEP_REQ,
    output logic [31:0] LED_FREQ_Set,
    output logic [31:0] BZ_FREQ_Set,
    output logic [31:0] LEDR_Puty_Set,
    output logic [31:0] LEDG_Puty_Set,
    output logic [31:0] LEDB_Puty_Set,
    output logic [2:0]  SEQ_STATE,
    output logic [1:0]  COLOR
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StUp     = 3'd1,
        StHoldHi = 3'd2,
        StDown   = 3'd3,
        StHoldLo = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] duty_q, duty_d;
    logic [1:0]  color_q, color_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] presc_q, presc_d;
    logic [31:0] beep_q, beep_d;
    logic [1:0]  mode_prev_q;

    logic [31:0] led_freq_q, bz_freq_q, bz_freq_d;
    logic [31:0] ledr_q, ledg_q, ledb_q;
    logic [31:0] ledr_d, ledg_d, ledb_d;
    logic [2:0]  seq_state_q;
    logic [1:0]  color_out_q;

    logic        mode_seq;
    logic        run;
    logic        restart;
    logic        tick;
    logic [31:0] div_m1;
    logic [32:0] up_sum;
    logic        hold_done;

    assign mode_seq  = (MODE == 2'd1) || (MODE == 2'd2);
    assign run       = EN && mode_seq;
    assign restart   = !run || (MODE != mode_prev_q);

    assign div_m1    = (STEP_DIV == 32'd0) ? 32'd0 : STEP_DIV - 32'd1;
    // >= rather than == so a shrinking STEP_DIV never strands the count above the limit
    assign tick      = (presc_q >= div_m1);

    assign up_sum    = {1'b0, duty_q} + {1'b0, PUTY_STEP};
    assign hold_done = ((hold_q + 32'd1) >= HOLD_TICKS);

    always_comb begin
        presc_d = presc_q + 32'd1;
        if (restart || tick) begin
            presc_d = 32'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        color_d = color_q;
        hold_d  = hold_q;
        if (restart) begin
            state_d = StIdle;
            duty_d  = 32'd0;
            color_d = 2'd0;
            hold_d  = 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StUp;
                    duty_d  = 32'd0;
                    hold_d  = 32'd0;
                end
                StUp: begin
                    if (tick) begin
                        // Covers both normal saturation and a ceiling lowered below the duty
                        if ({1'b0, PUTY_MAX} <= up_sum) begin
                            duty_d  = PUTY_MAX;
                            state_d = StHoldHi;
                        end else begin
                            duty_d = up_sum[31:0];
                        end
                        hold_d = 32'd0;
                    end
                end
                StHoldHi: begin
                    if (tick) begin
                        if (hold_done) begin
                            state_d = StDown;
                            hold_d  = 32'd0;
                        end else begin
                            hold_d = hold_q + 32'd1;
                        end
                    end
                end
                StDown: begin
                    if (tick) begin
                        if (duty_q <= PUTY_STEP) begin
                            duty_d  = 32'd0;
                            state_d = StHoldLo;
                        end else begin
                            duty_d = duty_q - PUTY_STEP;
                        end
                        hold_d = 32'd0;
                    end
                end
                StHoldLo: begin
                    if (tick) begin
                        if (hold_done) begin
                            state_d = StUp;
                            hold_d  = 32'd0;
                            if (MODE == 2'd2) begin
                                color_d = (color_q == 2'd2) ? 2'd0 : color_q + 2'd1;
                            end
                        end else begin
                            hold_d = hold_q + 32'd1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    duty_d  = 32'd0;
                    hold_d  = 32'd0;
                end
            endcase
        end
    end

    // Beep gate: EN low clears, a request (re)loads and beats a same-cycle decrement
    always_comb begin
        beep_d = beep_q;
        if (!EN) begin
            beep_d = 32'd0;
        end else if (BEEP_REQ) begin
            beep_d = BEEP_TICKS;
        end else if (tick && (beep_q != 32'd0)) begin
            beep_d = beep_q - 32'd1;
        end
    end

    always_comb begin
        ledr_d = HOST_LEDR_Puty;
        ledg_d = HOST_LEDG_Puty;
        ledb_d = HOST_LEDB_Puty;
        if (run) begin
            if (MODE == 2'd1) begin
                ledr_d = duty_q;
                ledg_d = duty_q;
                ledb_d = duty_q;
            end else begin
                ledr_d = 32'd0;
                ledg_d = 32'd0;
                ledb_d = 32'd0;
                case (color_q)
                    2'd0:    ledr_d = duty_q;
                    2'd1:    ledg_d = duty_q;
                    default: ledb_d = duty_q;
                endcase
            end
        end
    end

    always_comb begin
        bz_freq_d = HOST_BZ_FREQ;
        if (mode_seq && (beep_q == 32'd0)) begin
            bz_freq_d = 32'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            duty_q      <= 32'd0;
            color_q     <= 2'd0;
            hold_q      <= 32'd0;
            presc_q     <= 32'd0;
            beep_q      <= 32'd0;
            mode_prev_q <= 2'd0;
            led_freq_q  <= 32'd0;
            bz_freq_q   <= 32'd0;
            ledr_q      <= 32'd0;
            ledg_q      <= 32'd0;
            ledb_q      <= 32'd0;
            seq_state_q <= 3'd0;
            color_out_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            color_q     <= color_d;
            hold_q      <= hold_d;
            presc_q     <= presc_d;
            beep_q      <= beep_d;
            mode_prev_q <= MODE;
            led_freq_q  <= HOST_LED_FREQ;
            bz_freq_q   <= bz_freq_d;
            ledr_q      <= ledr_d;
            ledg_q      <= ledg_d;
            ledb_q      <= ledb_d;
            seq_state_q <= state_q;
            color_out_q <= color_q;
        end
    end

    assign LED_FREQ_Set  = led_freq_q;
    assign BZ_FREQ_Set   = bz_freq_q;
    assign LEDR_Puty_Set = ledr_q;
    assign LEDG_Puty_Set = ledg_q;
    assign LEDB_Puty_Set = ledb_q;
    assign SEQ_STATE     = seq_state_q;
    assign COLOR         = color_out_q;

endmodule

// File: tb/tb_bzled_seq_ctrl.sv
// Directed, table-driven bench for bzled_seq_ctrl: reset, pass-through, breathe,
// colour cycle, aborts, ceiling/divider edges and beep timing.
module tb_bzled_seq_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [1:0]  MODE;
    logic [31:0] STEP_DIV;
    logic [31:0] PUTY_MAX;
    logic [31:0] HOST_LED_FREQ;
    logic [31:0] HOST_BZ_FREQ;
    logic [31:0] HOST_LEDR_Puty;
    logic [31:0] HOST_LEDG_Puty;
    logic [31:0] HOST_LEDB_Puty;
    logic        BEEP_REQ;
    logic [31:0] LED_FREQ_Set;
    logic [31:0] BZ_FREQ_Set;
    logic [31:0] LEDR_Puty_Set;
    logic [31:0] LEDG_Puty_Set;
    logic [31:0] LEDB_Puty_Set;
    logic [2:0]  SEQ_STATE;
    logic [1:0]  COLOR;

    always #5 CLK = ~CLK;

    bzled_seq_ctrl #(
        .PUTY_STEP (32'd100),
        .HOLD_TICKS(2),
        .BEEP_TICKS(16)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .EN            (EN),
        .MODE          (MODE),
        .STEP_DIV      (STEP_DIV),
        .PUTY_MAX      (PUTY_MAX),
        .HOST_LED_FREQ (HOST_LED_FREQ),
        .HOST_BZ_FREQ  (HOST_BZ_FREQ),
        .HOST_LEDR_Puty(HOST_LEDR_Puty),
        .HOST_LEDG_Puty(HOST_LEDG_Puty),
        .HOST_LEDB_Puty(HOST_LEDB_Puty),
        .BEEP_REQ      (BEEP_REQ),
        .LED_FREQ_Set  (LED_FREQ_Set),
        .BZ_FREQ_Set   (BZ_FREQ_Set),
        .LEDR_Puty_Set (LEDR_Puty_Set),
        .LEDG_Puty_Set (LEDG_Puty_Set),
        .LEDB_Puty_Set (LEDB_Puty_Set),
        .SEQ_STATE     (SEQ_STATE),
        .COLOR         (COLOR)
    );

    typedef struct {
        int          cyc;
        logic [31:0] r;
        logic [31:0] g;
        logic [31:0] b;
        logic [2:0]  st;
        logic [1:0]  col;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cur     = 0;
    vec_t brv[13];
    vec_t ccv[9];

    function automatic vec_t mk(input int c, input logic [31:0] r, input logic [31:0] g,
                                input logic [31:0] b, input logic [2:0] st,
                                input logic [1:0] col);
        vec_t v;
        v.cyc = c;
        v.r   = r;
        v.g   = g;
        v.b   = b;
        v.st  = st;
        v.col = col;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One edge with EN low forces a clean restart; counting begins at the first EN-high edge
    task automatic start_run(input logic [1:0] m);
        EN   = 1'b0;
        MODE = m;
        step(1);
        EN  = 1'b1;
        cur = 0;
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        while (cur < v.cyc) begin
            step(1);
            cur++;
        end
        check($sformatf("%s c%0d R", tag, v.cyc), LEDR_Puty_Set, v.r);
        check($sformatf("%s c%0d G", tag, v.cyc), LEDG_Puty_Set, v.g);
        check($sformatf("%s c%0d B", tag, v.cyc), LEDB_Puty_Set, v.b);
        check($sformatf("%s c%0d state", tag, v.cyc), {29'd0, SEQ_STATE}, {29'd0, v.st});
        check($sformatf("%s c%0d color", tag, v.cyc), {30'd0, COLOR}, {30'd0, v.col});
    endtask

    task automatic beep_run(input int retrig_at, input int span, input int exp_len);
        int cnt;
        cnt = 0;
        EN   = 1'b0;
        MODE = 2'd1;
        step(1);
        EN = 1'b1;
        step(9);
        // Request lands on the edge where the prescaler wraps, so ticks follow every 10 cycles
        BEEP_REQ = 1'b1;
        step(1);
        BEEP_REQ = 1'b0;
        for (int i = 0; i < span; i++) begin
            if (i == retrig_at) BEEP_REQ = 1'b1;
            step(1);
            BEEP_REQ = 1'b0;
            if (BZ_FREQ_Set == 32'd4000) cnt++;
        end
        check($sformatf("beep length retrig=%0d", retrig_at), cnt, exp_len);
        check($sformatf("beep off retrig=%0d", retrig_at), BZ_FREQ_Set, 32'd0);
    endtask

    initial begin
        // Breathe, mode 1, STEP=100, MAX=250, HOLD=2; outputs lag state/duty by one edge
        brv[0]  = mk(1, 0, 0, 0, 3'd0, 2'd0);
        brv[1]  = mk(2, 0, 0, 0, 3'd1, 2'd0);
        brv[2]  = mk(3, 100, 100, 100, 3'd1, 2'd0);
        brv[3]  = mk(4, 200, 200, 200, 3'd1, 2'd0);
        brv[4]  = mk(5, 250, 250, 250, 3'd2, 2'd0);
        brv[5]  = mk(6, 250, 250, 250, 3'd2, 2'd0);
        brv[6]  = mk(7, 250, 250, 250, 3'd3, 2'd0);
        brv[7]  = mk(8, 150, 150, 150, 3'd3, 2'd0);
        brv[8]  = mk(9, 50, 50, 50, 3'd3, 2'd0);
        brv[9]  = mk(10, 0, 0, 0, 3'd4, 2'd0);
        brv[10] = mk(11, 0, 0, 0, 3'd4, 2'd0);
        brv[11] = mk(12, 0, 0, 0, 3'd1, 2'd0);
        brv[12] = mk(13, 100, 100, 100, 3'd1, 2'd0);

        // Colour cycle, mode 2: 10-cycle breaths, channel R then G then B then R
        ccv[0] = mk(3, 100, 0, 0, 3'd1, 2'd0);
        ccv[1] = mk(6, 250, 0, 0, 3'd2, 2'd0);
        ccv[2] = mk(11, 0, 0, 0, 3'd4, 2'd0);
        ccv[3] = mk(12, 0, 0, 0, 3'd1, 2'd1);
        ccv[4] = mk(13, 0, 100, 0, 3'd1, 2'd1);
        ccv[5] = mk(16, 0, 250, 0, 3'd2, 2'd1);
        ccv[6] = mk(23, 0, 0, 100, 3'd1, 2'd2);
        ccv[7] = mk(33, 100, 0, 0, 3'd1, 2'd0);
        ccv[8] = mk(36, 250, 0, 0, 3'd2, 2'd0);

        RST            = 1'b1;
        EN             = 1'b1;
        MODE           = 2'd1;
        STEP_DIV       = 32'd1;
        PUTY_MAX       = 32'd250;
        HOST_LED_FREQ  = 32'd1000;
        HOST_BZ_FREQ   = 32'd4000;
        HOST_LEDR_Puty = 32'd123;
        HOST_LEDG_Puty = 32'd22;
        HOST_LEDB_Puty = 32'd33;
        BEEP_REQ       = 1'b1;
        step(2);
        check("rst LED_FREQ", LED_FREQ_Set, 32'd0);
        check("rst BZ_FREQ", BZ_FREQ_Set, 32'd0);
        check("rst LEDR", LEDR_Puty_Set, 32'd0);
        check("rst LEDG", LEDG_Puty_Set, 32'd0);
        check("rst LEDB", LEDB_Puty_Set, 32'd0);
        check("rst state", {29'd0, SEQ_STATE}, 32'd0);
        check("rst color", {30'd0, COLOR}, 32'd0);

        RST      = 1'b0;
        MODE     = 2'd0;
        BEEP_REQ = 1'b0;
        step(1);
        check("pass LEDR", LEDR_Puty_Set, 32'd123);
        check("pass LED_FREQ", LED_FREQ_Set, 32'd1000);
        check("pass state", {29'd0, SEQ_STATE}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check($sformatf("mode0 BZ %0d", i), BZ_FREQ_Set, 32'd4000);
        end
        MODE           = 2'd3;
        HOST_LEDR_Puty = 32'd11;
        step(2);
        check("mode3 LEDR", LEDR_Puty_Set, 32'd11);
        check("mode3 LEDG", LEDG_Puty_Set, 32'd22);
        check("mode3 BZ", BZ_FREQ_Set, 32'd4000);

        start_run(2'd1);
        foreach (brv[i]) apply_vec("breathe", brv[i]);

        STEP_DIV = 32'd0;
        start_run(2'd1);
        foreach (brv[i]) apply_vec("div0", brv[i]);
        STEP_DIV = 32'd1;

        start_run(2'd2);
        foreach (ccv[i]) apply_vec("color", ccv[i]);

        // Drop EN mid-ramp while duty is 200
        start_run(2'd1);
        step(3);
        EN = 1'b0;
        step(2);
        check("abort_en state", {29'd0, SEQ_STATE}, 32'd0);
        check("abort_en LEDR", LEDR_Puty_Set, 32'd11);
        check("abort_en LEDG", LEDG_Puty_Set, 32'd22);
        check("abort_en LEDB", LEDB_Puty_Set, 32'd33);

        // Switch mode 1 -> 2 mid-ramp: restart from zero on R
        start_run(2'd1);
        step(3);
        MODE = 2'd2;
        step(2);
        check("abort_mode state", {29'd0, SEQ_STATE}, 32'd0);
        check("abort_mode LEDR", LEDR_Puty_Set, 32'd0);
        step(2);
        check("abort_mode LEDR ramp", LEDR_Puty_Set, 32'd100);
        check("abort_mode LEDG", LEDG_Puty_Set, 32'd0);
        check("abort_mode state up", {29'd0, SEQ_STATE}, 32'd1);

        // Lower the ceiling below the current duty
        start_run(2'd1);
        step(3);
        PUTY_MAX = 32'd80;
        step(2);
        check("ceil state", {29'd0, SEQ_STATE}, 32'd2);
        check("ceil LEDR", LEDR_Puty_Set, 32'd80);

        // Zero ceiling: duty stays 0 while the state walks the full loop
        PUTY_MAX = 32'd0;
        start_run(2'd1);
        step(3);
        check("max0 hold_hi", {29'd0, SEQ_STATE}, 32'd2);
        step(1);
        check("max0 LEDR", LEDR_Puty_Set, 32'd0);
        step(1);
        check("max0 down", {29'd0, SEQ_STATE}, 32'd3);
        step(1);
        check("max0 hold_lo", {29'd0, SEQ_STATE}, 32'd4);
        step(2);
        check("max0 up", {29'd0, SEQ_STATE}, 32'd1);
        PUTY_MAX = 32'd250;

        STEP_DIV = 32'd10;
        beep_run(-1, 300, 160);
        beep_run(99, 400, 260);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
